// File: rtl/fadd_share_arb.sv
// fadd_share_arb: round-robin sharing of one pipelined FP adder across NREQ lanes, with per-lane result buffers.
// Define FADD_ARB_STATS_EN to build the issue/conflict counters; otherwise both stat outputs are tied to 0.
module fadd_share_arb #(
  parameter int NREQ = 2,
  parameter int LAT  = 1,
  parameter int TAGW = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_sub,
  input  logic [32*NREQ-1:0]   req_x1,
  input  logic [32*NREQ-1:0]   req_x2,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      resp_valid,
  input  logic [NREQ-1:0]      resp_ready,
  output logic [32*NREQ-1:0]   resp_y,
  output logic [31:0]          fu_x1,
  output logic [31:0]          fu_x2,
  input  logic [31:0]          fu_y,
  output logic [31:0]          stat_issue,
  output logic [31:0]          stat_conflict
);
  logic [NREQ-1:0] busy, elig, grant, rot;
  logic [TAGW-1:0] rr_ptr, g;
  logic [TAGW-1:0] tt [LAT];
  logic [LAT-1:0]  tv;
  logic [31:0]     x1, x2;
  logic            any, sub;
  int              off;
  assign elig = req_valid & ~busy;
  // rot[k] is the lane k places after rr_ptr, so the lowest set bit is the winner
  always_comb begin
    rot = NREQ'({elig, elig} >> rr_ptr);
    any = |elig;
    off = 0;
    for (int k = NREQ-1; k >= 0; k--) if (rot[k]) off = k;
    g = TAGW'((int'(rr_ptr) + off) % NREQ);
    grant = NREQ'(any) << g;
    x1 = '0;
    x2 = '0;
    sub = 1'b0;
    for (int i = 0; i < NREQ; i++) if (grant[i]) begin
      x1 = req_x1[32*i +: 32];
      x2 = req_x2[32*i +: 32];
      sub = req_sub[i];
    end
  end
  assign req_ready = grant;
  assign fu_x1 = x1;
  assign fu_x2 = {x2[31] ^ sub, x2[30:0]};
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      rr_ptr <= '0;
      busy <= '0;
      tv <= '0;
      resp_valid <= '0;
      resp_y <= '0;
      for (int k = 0; k < LAT; k++) tt[k] <= '0;
    end else begin
      rr_ptr <= any ? TAGW'((int'(g) + 1) % NREQ) : rr_ptr;
      tv[0] <= any;
      tt[0] <= g;
      for (int k = 1; k < LAT; k++) begin
        tv[k] <= tv[k-1];
        tt[k] <= tt[k-1];
      end
      for (int i = 0; i < NREQ; i++) begin
        if (resp_valid[i] && resp_ready[i]) begin
          resp_valid[i] <= 1'b0;
          busy[i] <= 1'b0;
        end
        if (tv[LAT-1] && tt[LAT-1] == TAGW'(i)) begin
          resp_valid[i] <= 1'b1;
          resp_y[32*i +: 32] <= fu_y;
        end
        if (grant[i]) busy[i] <= 1'b1;
      end
    end
`ifdef FADD_ARB_STATS_EN
  logic [31:0] n_issue, n_conf;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      n_issue <= '0;
      n_conf <= '0;
    end else begin
      n_issue <= n_issue + 32'(any);
      n_conf <= n_conf + 32'($countones(elig) >= 2);
    end
  assign stat_issue = n_issue;
  assign stat_conflict = n_conf;
`else
  assign stat_issue = '0;
  assign stat_conflict = '0;
`endif
endmodule
